// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Brief    : Multi-cycle control FSM for the MIPS-subset datapath. Sequences
//            FETCH/DECODE/EXEC/MEM/WB and decodes all datapath mux selects
//            and write enables from the IR and the ALU zero flag.
//            Optional build macro MC_CTRL_ILLEGAL_HALT_EN: unsupported
//            instructions park the FSM in HALT (illegal=1) until reset;
//            otherwise they retire as a 2-cycle nop.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
  parameter int PC_SRC_W = 2,
  parameter int ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instr,
  input  logic                zero,
  output logic                IRWr,
  output logic                PCWr,
  output logic [PC_SRC_W-1:0] PCSrc,
  output logic [1:0]          EOp,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                ALUSrc,
  output logic                RegWr,
  output logic [1:0]          RegDst,
  output logic [1:0]          MemtoReg,
  output logic                MemWr,
  output logic                done,
  output logic                illegal,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [5:0] w_op, w_funct;
  logic w_rtype, w_addu, w_subu, w_jr, w_nop;
  logic w_ori, w_lui, w_addiu, w_lw, w_sw, w_beq, w_j, w_jal;
  logic w_to_exec;
  logic [1:0]         w_eop;
  logic [ALUOP_W-1:0] w_aluop;
  logic               w_alusrc;

  assign w_op    = instr[31:26];
  assign w_funct = instr[5:0];
  assign w_rtype = (w_op == 6'b000000);
  assign w_nop   = (instr == 32'h0000_0000);
  assign w_addu  = w_rtype && (w_funct == 6'b100001);
  assign w_subu  = w_rtype && (w_funct == 6'b100011);
  assign w_jr    = w_rtype && (w_funct == 6'b001000);
  assign w_ori   = (w_op == 6'b001101);
  assign w_lui   = (w_op == 6'b001111);
  assign w_addiu = (w_op == 6'b001001);
  assign w_lw    = (w_op == 6'b100011);
  assign w_sw    = (w_op == 6'b101011);
  assign w_beq   = (w_op == 6'b000100);
  assign w_j     = (w_op == 6'b000010);
  assign w_jal   = (w_op == 6'b000011);

  // Instructions that need the ALU and therefore continue past DECODE
  assign w_to_exec = w_addu | w_subu | w_ori | w_lui | w_addiu |
                     w_lw | w_sw | w_beq;

  // Per-instruction extender/ALU settings, held through EXEC, MEM and WB
  always_comb begin
    w_eop    = 2'b00;
    w_aluop  = ALUOP_W'(0);
    w_alusrc = 1'b0;
    if (w_subu) begin
      w_aluop = ALUOP_W'(1);
    end else if (w_ori) begin
      w_eop    = 2'b01;
      w_aluop  = ALUOP_W'(2);
      w_alusrc = 1'b1;
    end else if (w_lui) begin
      w_eop    = 2'b10;
      w_alusrc = 1'b1;
    end else if (w_addiu | w_lw | w_sw) begin
      w_alusrc = 1'b1;
    end else if (w_beq) begin
      w_eop   = 2'b11;
      w_aluop = ALUOP_W'(1);
    end
  end

  // State register; undefined encodings are recovered by the next-state logic
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore output decode; reset masks every enable last
  always_comb begin
    state_d  = S_FETCH;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    PCSrc    = PC_SRC_W'(0);
    EOp      = 2'b00;
    ALUOp    = ALUOP_W'(0);
    ALUSrc   = 1'b0;
    RegWr    = 1'b0;
    RegDst   = 2'b00;
    MemtoReg = 2'b00;
    MemWr    = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      EOp    = w_eop;
      ALUOp  = w_aluop;
      ALUSrc = w_alusrc;
    end
    case (state_q)
      S_FETCH: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (w_j | w_jal) begin
          PCWr  = 1'b1;
          PCSrc = PC_SRC_W'(2);
          done  = 1'b1;
          if (w_jal) begin
            RegWr    = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
        end else if (w_jr) begin
          PCWr  = 1'b1;
          PCSrc = PC_SRC_W'(3);
          done  = 1'b1;
        end else if (w_nop) begin
          done = 1'b1;
        end else if (w_to_exec) begin
          state_d = S_EXEC;
        end else begin
`ifdef MC_CTRL_ILLEGAL_HALT_EN
          state_d = S_HALT;
`else
          done = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        if (w_beq) begin
          PCSrc = PC_SRC_W'(1);
          PCWr  = zero;
          done  = 1'b1;
        end else if (w_lw | w_sw) begin
          state_d = S_MEM;
        end else if (w_to_exec) begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (w_sw) begin
          MemWr = 1'b1;
          done  = 1'b1;
        end else if (w_lw) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        RegWr    = 1'b1;
        done     = 1'b1;
        RegDst   = w_rtype ? 2'b01 : 2'b00;
        MemtoReg = w_lw ? 2'b01 : 2'b00;
      end
`ifdef MC_CTRL_ILLEGAL_HALT_EN
      S_HALT: begin
        illegal = 1'b1;
        state_d = S_HALT;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      IRWr    = 1'b0;
      PCWr    = 1'b0;
      RegWr   = 1'b0;
      MemWr   = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire
